// File: rtl/haz_pkg.sv
// Shared state encoding and constants for the N-channel hazard resolver.
package haz_pkg;

  localparam int STATE_W = 3;
  localparam int PERF_W  = 16;

  typedef enum logic [STATE_W-1:0] {
    IDLE       = 3'd0,
    FWD        = 3'd1,
    STALL_DATA = 3'd2,
    STALL_STR  = 3'd3,
    WAIT_BR    = 3'd4,
    FLUSH      = 3'd5
  } haz_state_t;

  function automatic logic is_stall_state(input haz_state_t s);
    return (s == STALL_DATA) || (s == STALL_STR) || (s == WAIT_BR);
  endfunction

endpackage

// File: rtl/haz_rr_arb.sv
// Round-robin arbiter for the shared structural resource: registered one-hot
// grant, search starts at the pointer and the pointer moves past the winner.
module haz_rr_arb #(
  parameter int NUM_STR = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               inhibit,
  input  logic [NUM_STR-1:0] req,
  output logic [NUM_STR-1:0] grant
);

  localparam int PTR_W = $clog2(NUM_STR);
  localparam int SUM_W = PTR_W + 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] idx;
  logic [SUM_W-1:0] sum;
  logic             found;

  // First requester at or after the pointer, wrapping modulo NUM_STR.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < NUM_STR; i++) begin
      sum = {1'b0, ptr} + SUM_W'(i);
      idx = (sum >= SUM_W'(NUM_STR)) ? PTR_W'(sum - SUM_W'(NUM_STR)) : sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant <= '0;
      ptr   <= '0;
    end else if (ena) begin
      if (inhibit || !found) begin
        grant <= '0;
      end else begin
        grant <= NUM_STR'(1) << win_idx;
        ptr   <= (win_idx == PTR_W'(NUM_STR - 1)) ? '0 : win_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/haz_resolver_nch.sv
// N-channel pipeline hazard resolver: registered stall/flush/forward controls,
// round-robin structural grant and stall watchdog. HAZ_PERF_CNT_EN adds perf counters.
module haz_resolver_nch
  import haz_pkg::*;
#(
  parameter int NUM_STR      = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_STALL    = 15,
  parameter int CNT_W        = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               data_haz,
  input  logic               fwd_ok,
  input  logic [NUM_STR-1:0] str_req,
  input  logic               ctrl_haz,
  input  logic               br_resolved,
  input  logic               br_correct,
  output logic               stall,
  output logic               flush,
  output logic               fwd_en,
  output logic [NUM_STR-1:0] str_grant,
  output logic [STATE_W-1:0] state_o,
  output logic [CNT_W-1:0]   stall_len,
  output logic               timeout
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]  perf_stall_cyc,
  output logic [PERF_W-1:0]  perf_flush_cnt
`endif
);

  localparam int FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  haz_state_t       state;
  haz_state_t       next_state;
  haz_state_t       from_idle;
  logic [FL_W-1:0]  flush_left;
  logic [CNT_W-1:0] len_inc;
  logic             mispred;
  logic             str_conf;
  logic             wd_fire;
  logic             flush_entry;

  assign mispred     = ctrl_haz & br_resolved & ~br_correct;
  assign str_conf    = $countones(str_req) > 1;
  assign wd_fire     = is_stall_state(state) && (stall_len == CNT_W'(MAX_STALL));
  assign len_inc     = (stall_len == '1) ? stall_len : stall_len + 1'b1;
  assign flush_entry = (next_state == FLUSH) && (state != FLUSH);
  assign state_o     = state;

  always_comb begin
    from_idle = IDLE;
    if (mispred)                    from_idle = FLUSH;
    else if (ctrl_haz & ~br_resolved) from_idle = WAIT_BR;
    else if (data_haz & fwd_ok)     from_idle = FWD;
    else if (data_haz)              from_idle = STALL_DATA;
    else if (str_conf)              from_idle = STALL_STR;
  end

  // Mispredicts and the watchdog override every state except an ongoing flush.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, FWD:  next_state = from_idle;
      STALL_DATA: begin
        if (data_haz & fwd_ok) next_state = FWD;
        else if (!data_haz)    next_state = IDLE;
      end
      STALL_STR:  if (!str_conf) next_state = IDLE;
      WAIT_BR:    if ((br_resolved & br_correct) | ~ctrl_haz) next_state = IDLE;
      FLUSH:      if (flush_left == '0) next_state = IDLE;
      default:    next_state = IDLE;
    endcase
    if ((state != FLUSH) && (mispred || wd_fire)) next_state = FLUSH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      stall      <= 1'b0;
      flush      <= 1'b0;
      fwd_en     <= 1'b0;
      timeout    <= 1'b0;
      stall_len  <= '0;
      flush_left <= '0;
    end else if (ena) begin
      state     <= next_state;
      stall     <= is_stall_state(next_state);
      flush     <= (next_state == FLUSH);
      fwd_en    <= (next_state == FWD);
      timeout   <= wd_fire;
      stall_len <= is_stall_state(next_state) ? len_inc : '0;
      if (flush_entry)
        flush_left <= FL_W'(FLUSH_CYCLES - 1);
      else if ((state == FLUSH) && (flush_left != '0))
        flush_left <= flush_left - 1'b1;
    end
  end

  haz_rr_arb #(
    .NUM_STR (NUM_STR)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .inhibit (state == FLUSH),
    .req     (str_req),
    .grant   (str_grant)
  );

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
    end else if (ena) begin
      if (stall && (perf_stall_cyc != '1)) perf_stall_cyc <= perf_stall_cyc + 1'b1;
      if (flush_entry && (perf_flush_cnt != '1)) perf_flush_cnt <= perf_flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_haz_resolver_nch.sv
// Self-checking bench for haz_resolver_nch: vector table, hand-written corner
// sequences and randomized traffic against a behavioural reference model.
module tb_haz_resolver_nch;

  localparam int NS    = 4;
  localparam int FLC   = 2;
  localparam int MAXST = 15;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena, data_haz, fwd_ok, ctrl_haz, br_resolved, br_correct;
  logic [NS-1:0] str_req;
  logic          stall, flush, fwd_en, timeout;
  logic [NS-1:0] str_grant;
  logic [2:0]    state_o;
  logic [CW-1:0] stall_len;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0]   perf_stall_cyc, perf_flush_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic       ena, data, fwd, ctrl, res, cor;
    logic [3:0] req;
  } stim_t;

  typedef struct {
    stim_t      s;
    int         st, stl, fls, fw, len;
    logic [3:0] gnt;
  } vec_t;

  // Reference model state, kept as plain integers.
  int         m_state, m_left, m_len, m_ptr;
  logic [3:0] m_grant;
  int         m_tmo;

  haz_resolver_nch #(
    .NUM_STR      (NS),
    .FLUSH_CYCLES (FLC),
    .MAX_STALL    (MAXST),
    .CNT_W        (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .data_haz    (data_haz),
    .fwd_ok      (fwd_ok),
    .str_req     (str_req),
    .ctrl_haz    (ctrl_haz),
    .br_resolved (br_resolved),
    .br_correct  (br_correct),
    .stall       (stall),
    .flush       (flush),
    .fwd_en      (fwd_en),
    .str_grant   (str_grant),
    .state_o     (state_o),
    .stall_len   (stall_len),
    .timeout     (timeout)
`ifdef HAZ_PERF_CNT_EN
    ,
    .perf_stall_cyc (perf_stall_cyc),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic stim_t mks(input logic e, d, f, c, r, k, input logic [3:0] q);
    stim_t s;
    s.ena = e; s.data = d; s.fwd = f; s.ctrl = c; s.res = r; s.cor = k; s.req = q;
    return s;
  endfunction

  function automatic vec_t row(input logic d, f, c, r, k, input logic [3:0] q,
                               input int st, stl, fls, fw, input logic [3:0] g, input int len);
    vec_t v;
    v.s = mks(1'b1, d, f, c, r, k, q);
    v.st = st; v.stl = stl; v.fls = fls; v.fw = fw; v.gnt = g; v.len = len;
    return v;
  endfunction

  function automatic int is_stall_code(input int s);
    return (s == 2 || s == 3 || s == 4) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_left = 0; m_len = 0; m_ptr = 0; m_grant = '0; m_tmo = 0;
  endtask

  // Transition rules straight from the hazard priority list.
  task automatic model_update(input stim_t s);
    int cnt, ns, wd, mis;
    if (!s.ena) return;
    cnt = 0;
    for (int k = 0; k < NS; k++) cnt += int'(s.req[k]);
    mis = (s.ctrl && s.res && !s.cor) ? 1 : 0;
    wd  = (is_stall_code(m_state) != 0 && m_len == MAXST) ? 1 : 0;
    m_grant = '0;
    if (m_state != 5) begin
      for (int k = 0; k < NS; k++) begin
        int idx;
        idx = (m_ptr + k) % NS;
        if (s.req[idx]) begin
          m_grant = 4'(1 << idx);
          m_ptr   = (idx + 1) % NS;
          break;
        end
      end
    end
    if (m_state == 5) begin
      m_left--;
      ns = (m_left == 0) ? 0 : 5;
    end else if (wd != 0 || mis != 0) begin
      ns = 5;
    end else begin
      case (m_state)
        2:       ns = !s.data ? 0 : (s.fwd ? 1 : 2);
        3:       ns = (cnt > 1) ? 3 : 0;
        4:       ns = (!s.ctrl || (s.res && s.cor)) ? 0 : 4;
        default: begin
          if (s.ctrl && !s.res)   ns = 4;
          else if (s.data && s.fwd) ns = 1;
          else if (s.data)        ns = 2;
          else if (cnt > 1)       ns = 3;
          else                    ns = 0;
        end
      endcase
    end
    if (ns == 5 && m_state != 5) m_left = FLC;
    m_tmo   = wd;
    m_len   = (is_stall_code(ns) != 0) ? ((m_len + 1 > 15) ? 15 : m_len + 1) : 0;
    m_state = ns;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int st, stl, fls, fw,
                           input logic [3:0] g, input int len, tmo);
    check_output({tag, ".state"},   32'(state_o),   32'(st));
    check_output({tag, ".stall"},   32'(stall),     32'(stl));
    check_output({tag, ".flush"},   32'(flush),     32'(fls));
    check_output({tag, ".fwd_en"},  32'(fwd_en),    32'(fw));
    check_output({tag, ".grant"},   32'(str_grant), 32'(g));
    check_output({tag, ".len"},     32'(stall_len), 32'(len));
    check_output({tag, ".timeout"}, 32'(timeout),   32'(tmo));
  endtask

  // Drive at the falling edge, let one rising edge pass, sample at the next falling edge.
  task automatic apply_stimulus(input stim_t s);
    ena = s.ena; data_haz = s.data; fwd_ok = s.fwd; ctrl_haz = s.ctrl;
    br_resolved = s.res; br_correct = s.cor; str_req = s.req;
    @(posedge clk);
    model_update(s);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ena = 1'b1; data_haz = 0; fwd_ok = 0; ctrl_haz = 0; br_resolved = 0; br_correct = 0;
    str_req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset", 0, 0, 0, 0, 4'b0000, 0, 0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    vec_t  tbl[$];
    stim_t s;
    logic  hold_data, hold_ctrl;

    // Correct branch, mispredict, forwarding, data stall, structural round-robin.
    tbl.push_back(row(0,0,1,0,0,4'b0000, 4,1,0,0,4'b0000,1));
    tbl.push_back(row(0,0,1,0,0,4'b0000, 4,1,0,0,4'b0000,2));
    tbl.push_back(row(0,0,1,0,0,4'b0000, 4,1,0,0,4'b0000,3));
    tbl.push_back(row(0,0,1,1,1,4'b0000, 0,0,0,0,4'b0000,0));
    tbl.push_back(row(0,0,0,0,0,4'b0000, 0,0,0,0,4'b0000,0));
    tbl.push_back(row(0,0,1,1,0,4'b0000, 5,0,1,0,4'b0000,0));
    tbl.push_back(row(0,0,0,0,0,4'b0000, 5,0,1,0,4'b0000,0));
    tbl.push_back(row(0,0,0,0,0,4'b0000, 0,0,0,0,4'b0000,0));
    tbl.push_back(row(1,1,0,0,0,4'b0000, 1,0,0,1,4'b0000,0));
    tbl.push_back(row(0,0,0,0,0,4'b0000, 0,0,0,0,4'b0000,0));
    for (int i = 1; i <= 4; i++) tbl.push_back(row(1,0,0,0,0,4'b0000, 2,1,0,0,4'b0000,i));
    tbl.push_back(row(0,0,0,0,0,4'b0000, 0,0,0,0,4'b0000,0));
    tbl.push_back(row(0,0,0,0,0,4'b1011, 3,1,0,0,4'b0001,1));
    tbl.push_back(row(0,0,0,0,0,4'b1011, 3,1,0,0,4'b0010,2));
    tbl.push_back(row(0,0,0,0,0,4'b1011, 3,1,0,0,4'b1000,3));
    tbl.push_back(row(0,0,0,0,0,4'b1011, 3,1,0,0,4'b0001,4));
    tbl.push_back(row(0,0,0,0,0,4'b0000, 0,0,0,0,4'b0000,0));
    tbl.push_back(row(0,0,0,0,0,4'b0100, 0,0,0,0,4'b0100,0));
    tbl.push_back(row(0,0,0,0,0,4'b0001, 0,0,0,0,4'b0001,0));
    tbl.push_back(row(0,0,1,1,1,4'b0000, 0,0,0,0,4'b0000,0));
    tbl.push_back(row(0,0,0,0,0,4'b0011, 3,1,0,0,4'b0010,1));
    tbl.push_back(row(1,0,0,0,0,4'b0011, 3,1,0,0,4'b0001,2));
    tbl.push_back(row(1,0,0,0,0,4'b0000, 0,0,0,0,4'b0000,0));
    tbl.push_back(row(1,0,0,0,0,4'b0000, 2,1,0,0,4'b0000,1));
    tbl.push_back(row(1,1,0,0,0,4'b0000, 1,0,0,1,4'b0000,0));
    tbl.push_back(row(0,0,0,0,0,4'b0000, 0,0,0,0,4'b0000,0));
    tbl.push_back(row(1,1,1,0,0,4'b0000, 4,1,0,0,4'b0000,1));
    tbl.push_back(row(0,0,0,0,0,4'b0000, 0,0,0,0,4'b0000,0));

    @(negedge clk);
    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      apply_stimulus(tbl[i].s);
      check_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].stl, tbl[i].fls, tbl[i].fw,
                tbl[i].gnt, tbl[i].len, 0);
    end

    // Watchdog: a data stall held past MAX_STALL forces a recovery flush.
    s = mks(1,1,0,0,0,0,4'b0000);
    for (int i = 1; i <= MAXST; i++) begin
      apply_stimulus(s);
      check_all($sformatf("wd_stall%0d", i), 2, 1, 0, 0, 4'b0000, i, 0);
    end
    apply_stimulus(s);
    check_all("wd_fire", 5, 0, 1, 0, 4'b0000, 0, 1);
    apply_stimulus(s);
    check_all("wd_flush2", 5, 0, 1, 0, 4'b0000, 0, 0);
    apply_stimulus(s);
    check_all("wd_done", 0, 0, 0, 0, 4'b0000, 0, 0);
    apply_stimulus(mks(1,0,0,0,0,0,4'b0000));
    check_all("wd_idle", 0, 0, 0, 0, 4'b0000, 0, 0);

    // Mispredict preempts a data stall; ena low freezes the flush countdown.
    apply_stimulus(mks(1,1,0,0,0,0,4'b0000));
    check_all("pre_stall1", 2, 1, 0, 0, 4'b0000, 1, 0);
    apply_stimulus(mks(1,1,0,0,0,0,4'b0000));
    check_all("pre_stall2", 2, 1, 0, 0, 4'b0000, 2, 0);
    apply_stimulus(mks(1,1,0,1,1,0,4'b0000));
    check_all("pre_flush", 5, 0, 1, 0, 4'b0000, 0, 0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(mks(0,1,0,1,1,0,4'b1111));
      check_all($sformatf("freeze%0d", i), 5, 0, 1, 0, 4'b0000, 0, 0);
    end
    apply_stimulus(mks(1,0,0,0,0,0,4'b0000));
    check_all("resume_flush", 5, 0, 1, 0, 4'b0000, 0, 0);
    apply_stimulus(mks(1,0,0,0,0,0,4'b0000));
    check_all("resume_idle", 0, 0, 0, 0, 4'b0000, 0, 0);

    // Asynchronous reset in the middle of a flush takes effect immediately.
    apply_stimulus(mks(1,0,0,1,1,0,4'b0000));
    check_all("mid_flush", 5, 0, 1, 0, 4'b0000, 0, 0);
    #2 rst_n = 1'b0;
    #1 check_all("async_rst", 0, 0, 0, 0, 4'b0000, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Randomized traffic with sticky hazards so long stalls and watchdogs occur.
    hold_data = 1'b0;
    hold_ctrl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(9) == 0) hold_data = ~hold_data;
      if ($urandom_range(9) < 2)  hold_ctrl = ~hold_ctrl;
      s.ena  = ($urandom_range(9) != 0);
      s.data = hold_data;
      s.fwd  = ($urandom_range(15) == 0);
      s.ctrl = hold_ctrl;
      s.res  = ($urandom_range(5) == 0);
      s.cor  = ($urandom_range(3) != 0);
      s.req  = ($urandom_range(1) == 0) ? 4'b0000 : 4'($urandom);
      apply_stimulus(s);
      check_all($sformatf("rand%0d", i), m_state, is_stall_code(m_state),
                (m_state == 5) ? 1 : 0, (m_state == 1) ? 1 : 0, m_grant, m_len, m_tmo);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
